// File: rtl/dmem_bus_arbiter_if.sv
// dmem_bus_arbiter_if
// Bundles the two master request/ack channels, the shared decoder port and
// the status outputs of dmem_bus_arbiter.
// Optional: `define ARB_PERF_CNT_EN adds the grant/conflict counter outputs.
interface dmem_bus_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

`ifdef ARB_PERF_CNT_EN
  logic [15:0]   m0_grant_cnt;
  logic [15:0]   m1_grant_cnt;
  logic [15:0]   conflict_cnt;
`endif

  // arbiter side
  modport slave (
`ifdef ARB_PERF_CNT_EN
    output m0_grant_cnt, m1_grant_cnt, conflict_cnt,
`endif
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output mem_addr, mem_write, mem_wdata,
    input  mem_rdata,
    output busy, owner
  );

  // master / decoder side
  modport master (
`ifdef ARB_PERF_CNT_EN
    input  m0_grant_cnt, m1_grant_cnt, conflict_cnt,
`endif
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  mem_addr, mem_write, mem_wdata,
    output mem_rdata,
    input  busy, owner
  );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter
// Round-robin two-master arbiter in front of the data-memory/IO decoder.
// IO-region accesses (addr[IO_BIT]=1) hold the bus IO_WAIT extra cycles so
// the slower peripheral read path settles before read data is captured.
// Optional: `define ARB_PERF_CNT_EN adds saturating grant/conflict counters.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transaction; arbitrate pending requests
// ACCESS | drive latched request onto decoder; write strobe here only
// WAIT   | IO hold cycles, down-counter runs to terminal count 0
// DONE   | one-cycle ack to owner; round-robin pointer updated
module dmem_bus_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int IO_BIT  = 7,
  parameter int IO_WAIT = 1
) (
  input  logic                clk,
  input  logic                reset,
  dmem_bus_arbiter_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // counter is loaded with IO_WAIT-1 so that terminal count 0 marks the last WAIT cycle
  localparam bit         HAS_WAIT  = (IO_WAIT > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(IO_WAIT - 1) : 4'd0;

  logic [1:0]    r_state;
  logic          r_last;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;
  logic [3:0]    r_wait_cnt;

  logic          w_grant_valid;
  logic          w_grant_idx;
  logic          w_io_hold;
  logic          w_capture;

  // pick a master: lone requester wins, a tie goes to the one not served last
  always_comb begin
    w_grant_valid = bus.m0_req | bus.m1_req;
    w_grant_idx   = bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      w_grant_idx = ~r_last;
    end
  end

  assign w_io_hold = r_addr[IO_BIT] && HAS_WAIT;
  assign w_capture = ((r_state == S_ACCESS) && !w_io_hold) ||
                     ((r_state == S_WAIT) && (r_wait_cnt == 4'd0));

  // transaction sequencer with request latching and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_owner <= w_grant_idx;
            r_we    <= w_grant_idx ? bus.m1_we    : bus.m0_we;
            r_addr  <= w_grant_idx ? bus.m1_addr  : bus.m0_addr;
            r_wdata <= w_grant_idx ? bus.m1_wdata : bus.m0_wdata;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (w_io_hold) begin
            r_wait_cnt <= WAIT_LOAD;
            r_state    <= S_WAIT;
          end else begin
            r_state    <= S_DONE;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state <= S_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        default: begin
          r_last  <= r_owner;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // read data lands only in the owner's register; writes leave both untouched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else if (w_capture && !r_we) begin
      if (r_owner) begin
        r_m1_rdata <= bus.mem_rdata;
      end else begin
        r_m0_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_write = (r_state == S_ACCESS) && r_we;
  assign bus.m0_ack    = (r_state == S_DONE) && !r_owner;
  assign bus.m1_ack    = (r_state == S_DONE) &&  r_owner;
  assign bus.m0_rdata  = r_m0_rdata;
  assign bus.m1_rdata  = r_m1_rdata;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.owner     = r_owner;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] r_m0_grant_cnt;
  logic [15:0] r_m1_grant_cnt;
  logic [15:0] r_conflict_cnt;

  // saturating counters: acks per master and IDLE cycles with both requests
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m0_grant_cnt <= 16'd0;
      r_m1_grant_cnt <= 16'd0;
      r_conflict_cnt <= 16'd0;
    end else begin
      if (bus.m0_ack && (r_m0_grant_cnt != 16'hFFFF)) begin
        r_m0_grant_cnt <= r_m0_grant_cnt + 16'd1;
      end
      if (bus.m1_ack && (r_m1_grant_cnt != 16'hFFFF)) begin
        r_m1_grant_cnt <= r_m1_grant_cnt + 16'd1;
      end
      if ((r_state == S_IDLE) && bus.m0_req && bus.m1_req &&
          (r_conflict_cnt != 16'hFFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
    end
  end

  assign bus.m0_grant_cnt = r_m0_grant_cnt;
  assign bus.m1_grant_cnt = r_m1_grant_cnt;
  assign bus.conflict_cnt = r_conflict_cnt;
`else
  // counters absent in this build
`endif

endmodule
